dot8: RTL

Pipelined signed dot-product stage of the matrix-vector engine. Each valid cycle it multiplies LANES matrix-row elements by LANES vector elements and reduces the products through a registered adder tree. The output is one DATAW-wide partial sum that feeds the `accum` stage directly. The first/last framing markers travel alongside the data so `accum` can build full row results across several beats.

---
 rtl/dot8.sv | 102 ++++++++++
 1 files changed

// File: rtl/dot8.sv
// dot8: pipelined signed dot product of LANES element pairs with a registered
// adder tree. The first/last framing sideband travels in lockstep with the data.
//
// Ports:
//   clk     - single clock, all state updates on the rising edge
//   rst     - synchronous active-high reset, clears every pipeline register
//   vec     - packed signed vector elements, lane i at [i*IWIDTH +: IWIDTH]
//   mat     - packed signed matrix-row elements, same lane packing
//   ivalid  - vec/mat/ifirst/ilast valid this cycle
//   ifirst  - first beat of a row (qualified by ivalid)
//   ilast   - last beat of a row (qualified by ivalid)
//   result  - signed sum over lanes of vec[i]*mat[i], holds while ovalid=0
//   ovalid  - result/ofirst/olast valid
//   ofirst  - delayed, valid-qualified ifirst
//   olast   - delayed, valid-qualified ilast
module dot8 #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned IWIDTH = 8,
  parameter int unsigned OWIDTH = 19
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES*IWIDTH-1:0]    vec,
  input  logic [LANES*IWIDTH-1:0]    mat,
  input  logic                       ivalid,
  input  logic                       ifirst,
  input  logic                       ilast,
  output logic signed [OWIDTH-1:0]   result,
  output logic                       ovalid,
  output logic                       ofirst,
  output logic                       olast
);

  localparam int unsigned LG = $clog2(LANES);
  localparam int unsigned PW = 2 * IWIDTH;
  localparam int unsigned NS = LG + 2;

  logic [LANES*IWIDTH-1:0] vec_q;
  logic [LANES*IWIDTH-1:0] mat_q;
  logic [NS-1:0]           vld_q;
  logic [NS-1:0]           fst_q;
  logic [NS-1:0]           lst_q;

  // Stage 0 operand capture plus the valid/first/last shift register.
  // Bit k of vld_q is the incoming valid for the data stage k+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q <= '0;
      mat_q <= '0;
      vld_q <= '0;
      fst_q <= '0;
      lst_q <= '0;
    end else begin
      vld_q <= {vld_q[NS-2:0], ivalid};
      fst_q <= {fst_q[NS-2:0], ifirst & ivalid};
      lst_q <= {lst_q[NS-2:0], ilast & ivalid};
      if (ivalid) begin
        vec_q <= vec;
        mat_q <= mat;
      end
    end
  end

  // Level 0 holds the products; level l holds LANES>>l partial sums that are
  // one bit wider than level l-1, so nothing can overflow on the way up.
  for (genvar l = 0; l <= LG; l++) begin : g_lvl
    localparam int unsigned W = PW + l;
    localparam int unsigned N = LANES >> l;

    logic signed [W-1:0] s [N];

    if (l == 0) begin : g_mul
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < N; j++) s[j] <= '0;
        end else if (vld_q[0]) begin
          for (int j = 0; j < N; j++) begin
            s[j] <= W'($signed(vec_q[j*IWIDTH +: IWIDTH])) *
                    W'($signed(mat_q[j*IWIDTH +: IWIDTH]));
          end
        end
      end
    end else begin : g_add
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < N; j++) s[j] <= '0;
        end else if (vld_q[l]) begin
          for (int j = 0; j < N; j++) begin
            s[j] <= W'(g_lvl[l-1].s[2*j]) + W'(g_lvl[l-1].s[2*j+1]);
          end
        end
      end
    end
  end

  // The tree root is already a register; widening to OWIDTH is pure sign extension.
  assign result = OWIDTH'(g_lvl[LG].s[0]);
  assign ovalid = vld_q[NS-1];
  assign ofirst = fst_q[NS-1];
  assign olast  = lst_q[NS-1];

endmodule
